sb_edge_cfg_param: RTL
======================

Name: sb_edge_cfg_param

Overview:
- Parametrised edge switch block for the bottom-row tiles of the fabric: routes CHAN_WIDTH left-channel tracks and NUM_PADS I/O-pad inputs between the top and left channel sides.
- Routing muxes are programmed through an internal configuration-chain shift register.
- A bit counter tracks chain loading; left-side outputs are gated until the chain is fully loaded.
- Successor to the fixed 9-track edge switch block; adds width and pad-count generics, a constant-0 mux input, load tracking and output gating.

Parameters:
- CHAN_WIDTH, 9, tracks per channel side; legal range 2..32.
- NUM_PADS, 10, pad inputs from the bottom-left grid; legal range 1..32.
- CFG_BITS, 2*CHAN_WIDTH (derived, localparam), routing config bits: 2 per left-track mux.

Ports:
- prog_clk  in  1  configuration clock; all state is clocked on its rising edge.
- prog_reset_n  in  1  asynchronous, active-low reset.
- ccff_head  in  1  configuration chain serial input.
- ccff_en  in  1  shift enable; while high, the chain shifts one bit per prog_clk.
- chany_top_in  in  CHAN_WIDTH  top-side channel inputs.
- chanx_left_in  in  CHAN_WIDTH  left-side channel inputs.
- pad_in  in  NUM_PADS  grid pad (inpad) inputs.
- chany_top_out  out  CHAN_WIDTH  top-side channel outputs.
- chanx_left_out  out  CHAN_WIDTH  left-side channel outputs.
- ccff_tail  out  1  configuration chain serial output.
- cfg_done  out  1  chain fully loaded; left outputs enabled.
- cfg_err  out  1  parity error flag (feature only; otherwise tied 0).

Behaviour:
- Clock/reset: one clock, prog_clk. prog_reset_n is asynchronous and active-low.
- Reset values: cfg[] = 0, bit_cnt = 0, cfg_done = 0, cfg_err = 0, ccff_tail = 0, chanx_left_out = 0.
- Chain length: L = CFG_BITS, or CFG_BITS+1 with the optional feature.
- Shift: on each prog_clk edge with ccff_en=1, cfg[0] <= ccff_head and cfg[k] <= cfg[k-1]. ccff_tail = cfg[L-1] (registered, one-bit-per-cycle pass-through).
- Loading FSM (bit_cnt, width clog2(L+1)):
  - EMPTY (bit_cnt = 0): ccff_en=1 -> LOADING, bit_cnt = 1.
  - LOADING: each ccff_en cycle increments bit_cnt. The edge where bit_cnt reaches L -> DONE; cfg_done = 1 on that same edge.
  - DONE: ccff_en=1 -> reload. bit_cnt = 1, cfg_done = 0 on that edge, state LOADING.
  - ccff_en=0 in any state: hold all state.
- Reset mid-load: returns to EMPTY and clears cfg[].
- Mux i (i = 0..CHAN_WIDTH-1):
  - sel = {cfg[2i], cfg[2i+1]}, with cfg[2i] as MSB.
  - sel 0 -> chany_top_in[(CHAN_WIDTH-i) % CHAN_WIDTH]
  - sel 1 -> pad_in[i % NUM_PADS]
  - sel 2 -> pad_in[(i+CHAN_WIDTH) % NUM_PADS]
  - sel 3 -> constant 0
- Left output: chanx_left_out[i] = cfg_done & ~cfg_err & mux_i. Combinational from inputs once configured; zero latency.
- Top output: chany_top_out[(CHAN_WIDTH-j) % CHAN_WIDTH] = chanx_left_in[j]. Ungated, combinational.
- Bit order: the first bit shifted lands in cfg[L-1]. For a load, send cfg[L-1] first and cfg[0] last.
- Simultaneous reset and ccff_en: reset wins.

Optional Feature:
- Macro: SB_CFG_PARITY_EN.
- Defined:
  - Chain gains a parity bit, cfg[CFG_BITS]; L = CFG_BITS+1.
  - On the edge entering DONE, cfg_err is registered as the XOR of all L bits, using the post-shift values; even parity is required.
  - cfg_err = 1 keeps chanx_left_out at 0.
  - cfg_err clears on reset or on the next reload start.
- Undefined: L = CFG_BITS; cfg_err tied 0.

Test Plan:
- Reset then idle, CHAN_WIDTH=9, NUM_PADS=10: all outputs 0. Drive chanx_left_in=9'h001 -> chany_top_out[0]=1, top passthrough active.
- Shift 18 bits, all 0, then chany_top_in=9'h1FF -> cfg_done=1 exactly on the 18th edge; chanx_left_out=9'h1FF.
- Load sel=1 for all muxes, pad_in=10'h2AA -> chanx_left_out[i] = pad_in[i], i.e. 9'h0AA. Shift 10 more bits -> cfg_done=0 from the first extra edge; chanx_left_out=0.
- Load mux 0 with sel=2, pad_in[9]=1 -> chanx_left_out[0]=1. Load sel=3 -> chanx_left_out[0]=0 for any input.
- Assert prog_reset_n=0 after 7 of 18 bits -> bit_cnt=0, ccff_tail=0. A full reload afterwards completes normally.
- With SB_CFG_PARITY_EN, 19 bits, odd parity -> cfg_done=1, cfg_err=1, chanx_left_out=0. Reload with even parity -> cfg_err=0, outputs enabled.

Source files
------------

// File: rtl/sb_edge_cfg_param.sv
// Parametrised bottom-row edge switch block: left-track muxes programmed by a serial config chain.
// Optional SB_CFG_PARITY_EN appends an even-parity bit to the chain and blocks left outputs on error.
module sb_edge_cfg_param #(
  parameter int CHAN_WIDTH = 9,
  parameter int NUM_PADS   = 10
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [NUM_PADS-1:0]   pad_in,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int CFG_BITS = 2 * CHAN_WIDTH;
`ifdef SB_CFG_PARITY_EN
  localparam int CHAIN_LEN = CFG_BITS + 1;
`else
  localparam int CHAIN_LEN = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_next;
  logic [CHAIN_LEN-1:0]  r_cfg;
  logic [CHAIN_LEN-1:0]  w_cfg_shifted;
  logic [CHAN_WIDTH-1:0] w_mux;

  assign w_cfg_shifted = {r_cfg[CHAIN_LEN-2:0], ccff_head};

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state   <= S_EMPTY;
      r_bit_cnt <= '0;
      r_cfg     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      if (ccff_en) begin
        r_cfg <= w_cfg_shifted;
      end
    end
  end

  // Any enabled shift out of DONE starts a fresh load at count 1.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    if (ccff_en) begin
      case (r_state)
        S_EMPTY: begin
          w_state_next   = S_LOADING;
          w_bit_cnt_next = CNT_W'(1);
        end
        S_LOADING: begin
          w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
            w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          w_state_next   = S_LOADING;
          w_bit_cnt_next = CNT_W'(1);
        end
        default: begin
          w_state_next   = S_EMPTY;
          w_bit_cnt_next = '0;
        end
      endcase
    end
  end

  assign cfg_done  = (r_state == S_DONE);
  assign ccff_tail = r_cfg[CHAIN_LEN-1];

`ifdef SB_CFG_PARITY_EN
  logic r_cfg_err;

  // Parity is judged on the chain contents as they stand after the final shift.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_cfg_err <= 1'b0;
    end else if (ccff_en) begin
      if (r_state == S_DONE) begin
        r_cfg_err <= 1'b0;
      end else if (w_state_next == S_DONE) begin
        r_cfg_err <= ^w_cfg_shifted;
      end
    end
  end

  assign cfg_err = r_cfg_err;
`else
  assign cfg_err = 1'b0;
`endif

  for (genvar gi = 0; gi < CHAN_WIDTH; gi++) begin : g_track
    localparam int TOP_IDX = (CHAN_WIDTH - gi) % CHAN_WIDTH;
    localparam int PAD_A   = gi % NUM_PADS;
    localparam int PAD_B   = (gi + CHAN_WIDTH) % NUM_PADS;

    logic [1:0] w_sel;
    assign w_sel = {r_cfg[2*gi], r_cfg[2*gi+1]};

    assign w_mux[gi] = (w_sel == 2'd0) ? chany_top_in[TOP_IDX] :
                       (w_sel == 2'd1) ? pad_in[PAD_A] :
                       (w_sel == 2'd2) ? pad_in[PAD_B] : 1'b0;

    assign chany_top_out[TOP_IDX] = chanx_left_in[gi];
  end

  assign chanx_left_out = (cfg_done && !cfg_err) ? w_mux : '0;

endmodule
